// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 16x oversampled UART receiver with majority-vote sampling,
// per-word parity/framing flags and a show-ahead receive FIFO.
module uart_rx_fifo #(
    parameter int unsigned CLK_HZ     = 1_000_000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_Rx,
    output logic [DATA_BITS-1:0] o_Data,
    output logic                 o_Valid,
    input  logic                 i_Ready,
    output logic                 o_ParityErr,
    output logic                 o_FrameErr,
    output logic                 o_Overrun,
    output logic                 o_Busy
);

    localparam int unsigned TICK_DIV = CLK_HZ / (BAUD * 16);
    localparam int unsigned TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned AW       = $clog2(FIFO_DEPTH);
    localparam int unsigned PW       = AW + 1;
    localparam int unsigned WW       = DATA_BITS + 2;
    localparam int unsigned BCW      = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_e;

    // ------------------------------------------------------------------
    // Input synchroniser and edge history
    // ------------------------------------------------------------------
    logic rx_meta_q;
    logic rx_sync_q;
    logic rx_prev_q;

    // Two-flop synchroniser plus one stage of history for falling-edge detect.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= i_Rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // ------------------------------------------------------------------
    // Free-running 16x oversampling tick
    // ------------------------------------------------------------------
    logic [TW-1:0] tick_cnt_q;
    logic          tick_c;

    assign tick_c = (tick_cnt_q == TW'(TICK_DIV - 1));

    // Wrapping divider; never re-phased to the incoming frame.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            tick_cnt_q <= '0;
        end else if (tick_c) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_q + TW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Receiver FSM state
    // ------------------------------------------------------------------
    state_e                 state_q, state_d;
    logic [3:0]             s_q, s_d;
    logic [BCW-1:0]         bit_cnt_q, bit_cnt_d;
    logic                   stop_cnt_q, stop_cnt_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   perr_q, perr_d;
    logic                   ferr_q, ferr_d;
    logic [1:0]             samp_q;
    logic                   maj_c;
    logic                   bit_mid_c;
    logic                   bit_end_c;
    logic                   push_c;
    logic [WW-1:0]          push_word_c;

    assign bit_mid_c = tick_c && (s_q == 4'd9);
    assign bit_end_c = tick_c && (s_q == 4'd15);
    assign maj_c     = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_sync_q) | (samp_q[1] & rx_sync_q);

    // Capture the s = 7 and s = 8 samples; the s = 9 sample is taken live in maj_c.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            samp_q <= 2'b11;
        end else if (tick_c && (s_q == 4'd7)) begin
            samp_q[0] <= rx_sync_q;
        end else if (tick_c && (s_q == 4'd8)) begin
            samp_q[1] <= rx_sync_q;
        end
    end

    // FSM state and frame registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            s_q        <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            shift_q    <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            s_q        <= s_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            shift_q    <= shift_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
        end
    end

    // Next-state logic: bit values resolve at s = 9, bits end at s = 15.
    always_comb begin
        state_d    = state_q;
        s_d        = s_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        shift_d    = shift_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        push_c     = 1'b0;

        if (tick_c) begin
            s_d = s_q + 4'd1;
        end

        case (state_q)
            S_IDLE: begin
                s_d = '0;
                if (rx_prev_q && !rx_sync_q) begin
                    state_d    = S_START;
                    bit_cnt_d  = '0;
                    stop_cnt_d = 1'b0;
                    perr_d     = 1'b0;
                    ferr_d     = 1'b0;
                end
            end
            S_START: begin
                if (bit_mid_c && maj_c) begin
                    state_d = S_IDLE;
                end else if (bit_end_c) begin
                    state_d   = S_DATA;
                    bit_cnt_d = '0;
                end
            end
            S_DATA: begin
                if (bit_mid_c) begin
                    shift_d = {maj_c, shift_q[DATA_BITS-1:1]};
                end
                if (bit_end_c) begin
                    if (bit_cnt_q == BCW'(DATA_BITS - 1)) begin
                        state_d    = (PARITY != 0) ? S_PARITY : S_STOP;
                        stop_cnt_d = 1'b0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BCW'(1);
                    end
                end
            end
            S_PARITY: begin
                // Mismatch when data+parity ones count disagrees with the configured sense.
                if (bit_mid_c) begin
                    perr_d = maj_c ^ (^shift_q) ^ (PARITY == 1);
                end
                if (bit_end_c) begin
                    state_d    = S_STOP;
                    stop_cnt_d = 1'b0;
                end
            end
            S_STOP: begin
                if (bit_mid_c) begin
                    if (!maj_c) begin
                        ferr_d = 1'b1;
                    end
                    // Push mid final stop bit so a back-to-back start edge is never missed.
                    if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
                        push_c  = 1'b1;
                        state_d = rx_sync_q ? S_IDLE : S_BREAK;
                    end
                end else if (bit_end_c) begin
                    stop_cnt_d = stop_cnt_q + 1'b1;
                end
            end
            S_BREAK: begin
                if (rx_sync_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        push_word_c = {ferr_d, perr_d, shift_q};
    end

    // ------------------------------------------------------------------
    // Receive FIFO
    // ------------------------------------------------------------------
    logic [WW-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic          valid_q;
    logic          overrun_q;
    logic          busy_q;
    logic          empty_c;
    logic          full_c;
    logic          pop_c;
    logic          wr_c;
    logic          drop_c;

    assign empty_c = (wptr_q == rptr_q);
    assign full_c  = (wptr_q[PW-1] != rptr_q[PW-1]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign pop_c   = valid_q && i_Ready;
    assign wr_c    = push_c && (!full_c || pop_c);
    assign drop_c  = push_c && full_c && !pop_c;

    // Pointer updates; a simultaneous pop frees the slot a full-FIFO push needs.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (wr_c) begin
            wptr_d = wptr_q + PW'(1);
        end
        if (pop_c && !empty_c) begin
            rptr_d = rptr_q + PW'(1);
        end
    end

    // Storage array, cleared on reset so the head reads zero.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_c) begin
            mem_q[wptr_q[AW-1:0]] <= push_word_c;
        end
    end

    // Pointers and registered status outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            valid_q   <= (wptr_d != rptr_d);
            overrun_q <= drop_c;
            busy_q    <= (state_d != S_IDLE);
        end
    end

    assign {o_FrameErr, o_ParityErr, o_Data} = mem_q[rptr_q[AW-1:0]];
    assign o_Valid   = valid_q;
    assign o_Overrun = overrun_q;
    assign o_Busy    = busy_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed + randomized frames into an 8N1 and an 8E1 receiver,
// checked against a frame-level reference model and per-DUT scoreboards.
module tb_uart_rx_fifo;

    localparam int BIT = 160;

    logic       clk;
    logic       rst;
    logic       rx_line;
    logic       sel_p;
    logic       rx_n, rx_p;
    logic       rdy_n, rdy_p;
    logic [7:0] data_n, data_p;
    logic       valid_n, valid_p;
    logic       perr_n, perr_p;
    logic       ferr_n, ferr_p;
    logic       ovr_n, ovr_p;
    logic       busy_n, busy_p;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int ovr_cnt_n = 0;
    int ovr_cnt_p = 0;

    logic [15:0] exp_n[$];
    logic [15:0] exp_p[$];
    logic [15:0] mon_e_n, mon_e_p;

    assign rx_n = sel_p ? 1'b1 : rx_line;
    assign rx_p = sel_p ? rx_line : 1'b1;

    uart_rx_fifo #(
        .CLK_HZ(1_600_000), .BAUD(10_000), .DATA_BITS(8),
        .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) dut_n (
        .i_clk(clk), .i_rst(rst), .i_Rx(rx_n),
        .o_Data(data_n), .o_Valid(valid_n), .i_Ready(rdy_n),
        .o_ParityErr(perr_n), .o_FrameErr(ferr_n),
        .o_Overrun(ovr_n), .o_Busy(busy_n)
    );

    uart_rx_fifo #(
        .CLK_HZ(1_600_000), .BAUD(10_000), .DATA_BITS(8),
        .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) dut_p (
        .i_clk(clk), .i_rst(rst), .i_Rx(rx_p),
        .o_Data(data_p), .o_Valid(valid_p), .i_Ready(rdy_p),
        .o_ParityErr(perr_p), .o_FrameErr(ferr_p),
        .o_Overrun(ovr_p), .o_Busy(busy_p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference: what a frame should deliver, as {ferr, perr, data}.
    function automatic logic [15:0] model(input logic [7:0] d, input bit even_par,
                                          input bit pbit, input bit stop_ok);
        bit perr;
        bit ferr;
        perr = even_par ? ((($countones(d) + int'(pbit)) % 2) == 1) : 1'b0;
        ferr = !stop_ok;
        return {6'b0, ferr, perr, d};
    endfunction

    // Serialise one frame: start, 8 data LSB first, optional parity, one stop bit.
    task automatic send_frame(input bit to_p, input logic [7:0] d, input bit pbit,
                              input bit stop_ok, input bit rel);
        sel_p   = to_p;
        rx_line = 1'b0;
        step(BIT);
        for (int i = 0; i < 8; i++) begin
            rx_line = d[i];
            step(BIT);
        end
        if (to_p) begin
            rx_line = pbit;
            step(BIT);
        end
        rx_line = stop_ok;
        step(BIT);
        if (rel) rx_line = 1'b1;
    endtask

    task automatic send_n(input logic [7:0] d);
        exp_n.push_back(model(d, 1'b0, 1'b0, 1'b1));
        send_frame(1'b0, d, 1'b0, 1'b1, 1'b1);
    endtask

    // Consumer side: every accepted head word must be the next scoreboard entry.
    always @(negedge clk) begin
        if (!rst) begin
            if (valid_n && rdy_n) begin
                if (exp_n.size() != 0) mon_e_n = exp_n.pop_front();
                else mon_e_n = 16'hFFFF;
                check("n_word", {6'b0, ferr_n, perr_n, data_n}, mon_e_n);
            end
            if (valid_p && rdy_p) begin
                if (exp_p.size() != 0) mon_e_p = exp_p.pop_front();
                else mon_e_p = 16'hFFFF;
                check("p_word", {6'b0, ferr_p, perr_p, data_p}, mon_e_p);
            end
            if (ovr_n) ovr_cnt_n++;
            if (ovr_p) ovr_cnt_p++;
        end
    end

    initial begin
        string       msg;
        logic [7:0]  d;
        bit          pbit;
        bit          bad_p;
        bit          stop_ok;
        int          ovr_base;

        rst     = 1'b1;
        rx_line = 1'b1;
        sel_p   = 1'b0;
        rdy_n   = 1'b1;
        rdy_p   = 1'b1;
        step(5);

        // Reset state.
        check("rst_n_outputs", {3'b0, valid_n, busy_n, ovr_n, perr_n, ferr_n, data_n}, 16'h0);
        check("rst_p_outputs", {3'b0, valid_p, busy_p, ovr_p, perr_p, ferr_p, data_p}, 16'h0);
        rst = 1'b0;
        step(20);

        // Back-to-back stream, no idle gap.
        msg = "Hello World!";
        ovr_base = ovr_cnt_n;
        for (int i = 0; i < msg.len(); i++) begin
            send_n(msg[i]);
        end
        step(30);
        check("hello_drained", 16'(exp_n.size()), 16'd0);
        check("hello_no_ovr", 16'(ovr_cnt_n - ovr_base), 16'd0);
        check("hello_valid_low", {15'b0, valid_n}, 16'd0);

        // Even parity: correct then wrong parity bit on 0x41.
        exp_p.push_back(model(8'h41, 1'b1, 1'b0, 1'b1));
        send_frame(1'b1, 8'h41, 1'b0, 1'b1, 1'b1);
        step(20);
        exp_p.push_back(model(8'h41, 1'b1, 1'b1, 1'b1));
        send_frame(1'b1, 8'h41, 1'b1, 1'b1, 1'b1);
        step(20);
        check("par_drained", 16'(exp_p.size()), 16'd0);

        // Randomized 8E1 frames with occasional parity and stop-bit faults.
        for (int k = 0; k < 10; k++) begin
            d       = 8'($urandom);
            bad_p   = ($urandom_range(3) == 0);
            stop_ok = ($urandom_range(3) != 0);
            pbit    = (^d) ^ bad_p;
            exp_p.push_back(model(d, 1'b1, pbit, stop_ok));
            send_frame(1'b1, d, pbit, stop_ok, 1'b1);
            step(stop_ok ? int'($urandom_range(40)) : 20 + int'($urandom_range(40)));
        end
        step(20);
        check("rand_drained", 16'(exp_p.size()), 16'd0);
        check("rand_no_ovr", 16'(ovr_cnt_p), 16'd0);

        // Framing error followed by a held-low line.
        exp_n.push_back(model(8'h55, 1'b0, 1'b0, 1'b0));
        send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b0);
        step(BIT * 15);
        check("break_busy", {15'b0, busy_n}, 16'd1);
        step(BIT * 15);
        rx_line = 1'b1;
        step(40);
        check("break_one_word", 16'(exp_n.size()), 16'd0);
        check("break_valid_low", {15'b0, valid_n}, 16'd0);
        check("break_idle", {15'b0, busy_n}, 16'd0);
        send_n(8'hA3);
        step(20);
        check("after_break", 16'(exp_n.size()), 16'd0);

        // Glitch shorter than half a bit.
        sel_p   = 1'b0;
        rx_line = 1'b0;
        step(64);
        check("glitch_busy", {15'b0, busy_n}, 16'd1);
        rx_line = 1'b1;
        step(60);
        check("glitch_rejected", {15'b0, busy_n}, 16'd0);
        check("glitch_no_word", {15'b0, valid_n}, 16'd0);
        step(BIT);

        // Overrun on a depth-4 FIFO with the consumer stalled.
        rdy_n    = 1'b0;
        ovr_base = ovr_cnt_n;
        for (int v = 1; v <= 4; v++) send_n(8'(v));
        step(20);
        check("ovr_none_yet", 16'(ovr_cnt_n - ovr_base), 16'd0);
        send_frame(1'b0, 8'h05, 1'b0, 1'b1, 1'b1);
        step(20);
        check("ovr_once", 16'(ovr_cnt_n - ovr_base), 16'd1);
        check("ovr_head", {6'b0, ferr_n, perr_n, data_n}, 16'h0001);
        rdy_n = 1'b1;
        step(10);
        check("ovr_drained", 16'(exp_n.size()), 16'd0);
        check("ovr_valid_low", {15'b0, valid_n}, 16'd0);

        // Reset mid-frame with a word already waiting.
        rdy_n = 1'b0;
        send_n(8'h11);
        step(20);
        check("pre_rst_head", {7'b0, valid_n, data_n}, 16'h0111);
        sel_p   = 1'b0;
        rx_line = 1'b0;
        step(BIT);
        d = 8'h7E;
        for (int i = 0; i < 4; i++) begin
            rx_line = d[i];
            step(BIT);
        end
        check("mid_frame_busy", {15'b0, busy_n}, 16'd1);
        rst = 1'b1;
        #1;
        check("rst_mid_outputs", {3'b0, valid_n, busy_n, ovr_n, perr_n, ferr_n, data_n}, 16'h0);
        exp_n.delete();
        rx_line = 1'b1;
        step(5);
        rst   = 1'b0;
        rdy_n = 1'b1;
        step(BIT * 2);
        check("post_rst_idle", {14'b0, valid_n, busy_n}, 16'd0);
        send_n(8'h3C);
        step(20);
        check("post_rst_word", 16'(exp_n.size()), 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
